arb_client: RTL and testbench
=============================

Name: arb_client

Overview:
- Requester-side agent for the 4-way round-robin arbiter: one instance per requester slot, driving one `req` bit and consuming the matching `grant` bit.
- Local logic queues burst commands. The agent raises `req`, waits for `grant`, issues the burst beats, then releases the slot so the arbiter can rotate.
- Monitors starvation and grant-protocol violations.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- LEN_W, 4, width of burst length field (beats-1)
- MAX_WAIT, 16, cycles in REQ without grant before `starve` sets
- CNT_W, 8, width of granted-burst counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  local command offered
- cmd_len  in  LEN_W  burst length minus 1
- cmd_ready  out  1  FIFO not full
- req  out  1  request to arbiter (registered)
- grant  in  1  grant from arbiter (arbiter-registered)
- beat_valid  out  1  bus beat issued this cycle
- beat_idx  out  LEN_W  index of current beat (registered counter)
- done  out  1  one-cycle pulse with the last beat
- starve  out  1  sticky, MAX_WAIT exceeded
- proto_err  out  1  sticky, grant misbehaviour
- grant_cnt  out  CNT_W  bursts granted, wraps

Behaviour:
- Reset:
  - all outputs 0 the cycle after rst is sampled high
  - FIFO emptied, FSM to IDLE, counters 0
  - `cmd_ready` is 1 after reset
  - reset mid-burst aborts the burst with no `done` pulse
- FIFO:
  - push when cmd_valid && cmd_ready; `cmd_ready` = !full
  - pop on the REQ->XFER transition
  - push and pop in the same cycle are both honoured, including when full (`cmd_ready` is still low when full, so no push occurs then)
- FSM states: IDLE, REQ, XFER, GAP.
- IDLE:
  - req=0
  - FIFO non-empty -> REQ
  - push at edge k gives req=1 from edge k+1
- REQ:
  - req=1
  - wait counter increments each cycle
  - when it reaches MAX_WAIT-1, starve<=1; FSM keeps waiting
  - grant sampled 1 -> XFER: latch head length, pop, beat counter=0, wait counter=0, grant_cnt+1
- XFER:
  - req=1; beat_valid = (state==XFER) && grant (combinational)
  - beat counter advances only on cycles with beat_valid
  - beat with beat_idx==latched len: done=1, then -> GAP
  - len=0 gives a single beat
- GAP:
  - req=0 for exactly one cycle so the arbiter can rotate
  - then -> REQ if FIFO non-empty, else IDLE
  - `req` is never held across back-to-back bursts
- Grant drop mid-burst (grant=0 in XFER before the last beat):
  - proto_err<=1
  - beat counter holds, FSM stays in XFER, resumes when grant returns
- grant=1 in IDLE or GAP for a cycle not immediately following an XFER exit: proto_err<=1, otherwise ignored.
  - The first GAP cycle tolerates residual grant from arbiter latency.
- Latency: min 1 cycle from grant sampled to first beat_valid; burst occupies len+1 granted cycles; req deasserts the cycle after `done`.
- Width: beat counter LEN_W bits, no overflow (bounded by len); grant_cnt wraps modulo 2^CNT_W.

Decomposition:
- Package arb_pkg:
  - typedef enum arb_client_state_t {IDLE, REQ, XFER, GAP}
  - default LEN_W/CNT_W constants
  - shared NUM_REQ=4 for the arbiter and its clients
- Sub-module arb_cmd_fifo:
  - sync FIFO, DEPTH x LEN_W, full/empty flags
  - simultaneous push/pop supported

Test Plan:
- Reset, push len=0, hold grant=1 from first req -> req high 1 cycle after push; single beat_valid with beat_idx=0 and done=1; GAP req=0 one cycle; grant_cnt=1.
- Push len=3, grant 2 cycles after req -> beat_idx 0,1,2,3 on consecutive cycles; done only on idx 3; req low the next cycle.
- MAX_WAIT=8, push, keep grant=0 for 10 cycles -> starve=1 after 8 REQ cycles; grant then -> burst completes normally; starve stays 1 until rst.
- Push 4 commands with grant=0 -> cmd_ready=0 after the 4th; first grant pops, giving cmd_ready=1 next cycle; all 4 bursts complete with a GAP between each; grant_cnt=4.
- len=3, drop grant for 2 cycles after beat 1 -> proto_err=1, beat_idx holds at 2, beats 2,3 follow when grant returns; single done.
- rst asserted during beat 2 of len=5 -> next cycle req=0, beat_valid=0, no done, FIFO empty, cmd_ready=1, grant_cnt=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its requester-side
// clients: the client FSM state type, default field widths, the number of
// requester slots, and a small state-decode helper.
package arb_pkg;

  // Requester slots served by one arbiter.
  localparam int unsigned NUM_REQ   = 4;

  // Default widths of the burst-length field and the granted-burst counter.
  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } arb_client_state_t;

  // The request line is held for the whole of REQ and XFER and dropped in
  // IDLE and GAP, so the arbiter always sees a low cycle between bursts.
  function automatic logic drives_req(arb_client_state_t s);
    return (s == REQ) || (s == XFER);
  endfunction

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous command FIFO holding burst lengths for one arbiter client.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset (empties FIFO)
//   push, din     write din when push is high and the FIFO is not full
//   pop           drop the head entry when pop is high and not empty
//   dout          head entry (valid while empty is low)
//   full, empty   occupancy flags
//
// Push and pop in the same cycle are both honoured.
module arb_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/arb_client.sv
// Requester-side agent for the 4-way round-robin arbiter. Queues local
// burst commands, requests the bus slot, issues one beat per granted cycle
// and then releases the slot for one cycle so the arbiter can rotate.
// Also flags starvation and grant-protocol violations.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   cmd_valid   local command offered
//   cmd_len     burst length minus 1
//   cmd_ready   command FIFO not full
//   req         registered request to the arbiter
//   grant       registered grant from the arbiter
//   beat_valid  a bus beat is issued this cycle
//   beat_idx    index of the current beat
//   done        one-cycle pulse with the last beat of a burst
//   starve      sticky: MAX_WAIT cycles in REQ without a grant
//   proto_err   sticky: grant dropped mid-burst or asserted unexpectedly
//   grant_cnt   number of bursts granted, wraps
module arb_client
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             grant,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             starve,
  output logic             proto_err,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_client_state_t state_q;
  arb_client_state_t state_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [LEN_W-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             last_beat;

  logic             req_q;
  logic             after_xfer_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic             starve_q;
  logic             perr_q;
  logic [CNT_W-1:0] grant_cnt_q;

  arb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_len),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cmd_ready  = !fifo_full;
    push       = cmd_valid && !fifo_full;
    beat_valid = (state_q == XFER) && grant;
    last_beat  = beat_valid && (beat_cnt_q == len_q);
    // REQ is only entered with a non-empty FIFO and nothing pops before
    // the grant, so the head is always valid here.
    pop        = (state_q == REQ) && grant;

    case (state_q)
      IDLE: if (!fifo_empty) state_d = REQ;
      REQ:  if (grant)       state_d = XFER;
      XFER: if (last_beat)   state_d = GAP;
      GAP:  state_d = fifo_empty ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      after_xfer_q <= 1'b0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      wait_q       <= '0;
      starve_q     <= 1'b0;
      perr_q       <= 1'b0;
      grant_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= drives_req(state_d);
      after_xfer_q <= (state_q == XFER);

      if (pop) begin
        len_q       <= fifo_head;
        grant_cnt_q <= grant_cnt_q + CNT_W'(1);
      end

      // Counter returns to zero after the last beat so beat_idx is quiet
      // between bursts; a dropped grant simply holds it.
      if (pop) begin
        beat_cnt_q <= '0;
      end else if (beat_valid) begin
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + LEN_W'(1);
      end

      // Wait counter saturates at MAX_WAIT-1; reaching it without a grant
      // marks starvation while the FSM keeps requesting.
      if ((state_q == REQ) && !grant) begin
        if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          starve_q <= 1'b1;
        end else begin
          wait_q <= wait_q + WAIT_W'(1);
        end
      end else begin
        wait_q <= '0;
      end

      // The cycle right after leaving XFER may still see the arbiter's
      // registered grant; only later idle-side grants are violations.
      if (((state_q == XFER) && !grant) ||
          (((state_q == IDLE) || (state_q == GAP)) && grant && !after_xfer_q)) begin
        perr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    req       = req_q;
    beat_idx  = beat_cnt_q;
    done      = last_beat;
    starve    = starve_q;
    proto_err = perr_q;
    grant_cnt = grant_cnt_q;
  end

endmodule

// File: tb/tb_arb_client.sv
module tb_arb_client;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             grant;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_idx;
  logic             done;
  logic             starve;
  logic             proto_err;
  logic [CNT_W-1:0] grant_cnt;

  always #5 clk = ~clk;

  arb_client #(
    .DEPTH    (DEPTH),
    .LEN_W    (LEN_W),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .req        (req),
    .grant      (grant),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .done       (done),
    .starve     (starve),
    .proto_err  (proto_err),
    .grant_cnt  (grant_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int unsigned mq[$];          // pending burst lengths
  int unsigned exp_burst_q[$]; // scoreboard: bursts still owed to the bus
  int unsigned mon_idx = 0;
  bit          m_ask = 0, m_burst = 0, m_gap = 0, m_starve = 0, m_perr = 0;
  int unsigned m_wait = 0, m_beats = 0, m_len = 0, m_gcnt = 0;

  always @(posedge clk) begin : model
    bit pushv;
    bit nonempty;
    if (rst) begin
      mq.delete(); exp_burst_q.delete(); mon_idx = 0;
      m_ask = 0; m_burst = 0; m_gap = 0; m_starve = 0; m_perr = 0;
      m_wait = 0; m_beats = 0; m_len = 0; m_gcnt = 0;
    end else begin
      pushv    = cmd_valid && (mq.size() < DEPTH);
      nonempty = (mq.size() != 0);
      if (m_burst) begin
        if (grant) begin
          if (m_beats == m_len) begin m_burst = 0; m_gap = 1; m_beats = 0; end
          else m_beats++;
        end else m_perr = 1;
      end else if (m_ask) begin
        if (grant) begin
          m_ask = 0; m_burst = 1; m_len = mq.pop_front(); m_beats = 0; m_wait = 0; m_gcnt++;
        end else begin
          m_wait++;
          if (m_wait >= MAX_WAIT) m_starve = 1;
        end
      end else if (m_gap) begin
        m_gap = 0; m_ask = nonempty;
      end else begin
        if (grant) m_perr = 1;
        m_ask = nonempty;
      end
      if (pushv) begin
        mq.push_back(int'(cmd_len));
        exp_burst_q.push_back(int'(cmd_len));
      end
    end
  end

  // Cycle-level output check against the model.
  always @(negedge clk) begin
    #2;
    check("req", req, m_ask || m_burst);
    check("cmd_ready", cmd_ready, mq.size() < DEPTH);
    check("beat_valid", beat_valid, m_burst && grant);
    check("done", done, m_burst && grant && (m_beats == m_len));
    check("starve", starve, m_starve);
    check("proto_err", proto_err, m_perr);
    check("grant_cnt", grant_cnt, m_gcnt % (1 << CNT_W));
  end

  // Scoreboard monitor: pops an owed burst whenever the bus finishes one.
  always @(negedge clk) begin
    #3;
    if (beat_valid === 1'b1) begin
      if (exp_burst_q.size() == 0) begin
        check("beat_without_cmd", beat_valid, 0);
      end else begin
        check("beat_idx", beat_idx, mon_idx);
        if (mon_idx == exp_burst_q[0]) begin
          check("burst_end_done", done, 1);
          void'(exp_burst_q.pop_front());
          mon_idx = 0;
        end else begin
          check("mid_burst_done", done, 0);
          mon_idx++;
        end
      end
    end
  end

  // ---------------- arbiter stand-in ----------------
  int unsigned grant_pct = 100;
  int unsigned glitch_pm = 0;
  int unsigned hold_off  = 0;
  bit          prev_req  = 0;

  always @(negedge clk) begin : arb
    logic g;
    if (hold_off != 0) begin
      grant = 1'b0;
      hold_off--;
    end else begin
      g = prev_req && (grant || ($urandom_range(99) < grant_pct));
      if (glitch_pm != 0 && $urandom_range(999) < glitch_pm) g = !g;
      grant = g;
    end
    prev_req = req;
  end

  // ---------------- stimulus ----------------
  task automatic push_cmd(input int unsigned len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_beat(input int unsigned idx, input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #2;
      if (beat_valid === 1'b1 && beat_idx == LEN_W'(idx)) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; grant = 1'b0;
    idle(2);
    @(negedge clk); rst = 1'b0; #2;
    check("reset_req", req, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_grant_cnt", grant_cnt, 0);

    // Single-beat burst.
    grant_pct = 100;
    push_cmd(0);
    idle(8);
    check("single_burst_cnt", grant_cnt, 1);

    // Four-beat burst.
    push_cmd(3);
    idle(12);

    // Starvation, then late grant.
    grant_pct = 0;
    push_cmd(2);
    idle(12);
    check("starve_set", starve, 1);
    grant_pct = 100;
    idle(15);
    check("starve_sticky", starve, 1);

    // Fill the FIFO with no grant, then drain.
    grant_pct = 0;
    for (int i = 0; i < 5; i++) push_cmd(i % 4);
    @(negedge clk); cmd_valid = 1'b0; #2;
    check("full_not_ready", cmd_ready, 0);
    grant_pct = 100;
    idle(60);
    check("four_bursts_cnt", grant_cnt, 7);

    // Grant dropped for two cycles after beat 1.
    push_cmd(3);
    wait_beat(1, "drop_wait_beat1");
    hold_off = 2;
    idle(15);
    check("drop_proto_err", proto_err, 1);

    // Reset during beat 2 of a long burst with another command queued.
    push_cmd(5);
    push_cmd(2);
    wait_beat(2, "rst_wait_beat2");
    rst = 1'b1; hold_off = 3;
    @(negedge clk); rst = 1'b0; #2;
    check("rst_req", req, 0);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_grant_cnt", grant_cnt, 0);
    @(negedge clk); #2;
    check("rst_fifo_empty_req", req, 0);

    // Randomized traffic with varying arbiter behaviour.
    for (int seg = 0; seg < 20; seg++) begin
      grant_pct = $urandom_range(100);
      glitch_pm = (seg % 3 == 0) ? 20 : 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        cmd_valid = ($urandom_range(99) < 35);
        cmd_len   = LEN_W'($urandom_range(15));
        rst       = ($urandom_range(399) == 0);
      end
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; glitch_pm = 0; grant_pct = 100;
    idle(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
